// File: rtl/wb_select_pipe_pkg.sv
// Shared definitions for the write-back select pipeline: FSM state encoding,
// default widths and the conventional source-index assignments.
package wb_pkg;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

    localparam int WB_DATA_W  = 16;
    localparam int WB_ADDR_W  = 3;
    localparam int WB_NUM_SRC = 4;
    localparam int WB_TIMEOUT = 15;

    // Source slots as wired at the register-file write port
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_RAM = 1;
    localparam int WB_SRC_IMM = 2;
    localparam int WB_SRC_PC  = 3;

endpackage

// File: rtl/wb_select_pipe_src_mux.sv
// NUM_SRC:1 indexed select of the flattened source bus. Out-of-range
// selects return zero; the caller never commits data for those.
module wb_src_mux #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         data
);

    // Indexed select; source i lives at bits [i*DATA_W +: DATA_W]
    always_comb begin
        data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) data = src_data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Registered write-back source selector. Accepts one request per cycle,
// writes immediately when the chosen source is ready, otherwise stalls in
// WAIT until it is. Illegal selects pulse err with no write.
// Optional macro WB_TIMEOUT_EN: abort a WAIT after TIMEOUT idle cycles.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int TIMEOUT = WB_TIMEOUT,
    localparam int SEL_W  = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEL_W-1:0]          req_sel,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic                      wb_en,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      busy,
    output logic                      err
);

    generate
        if (NUM_SRC < 2 || TIMEOUT < 1) begin : g_bad_cfg
            $error("wb_select_pipe: NUM_SRC must be >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    // One extra bit so the range check cannot collapse to a constant
    localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);

    wb_state_t         state, state_n;
    logic [SEL_W-1:0]  sel_q, sel_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] wb_addr_n;
    logic [DATA_W-1:0] wb_data_n;
    logic              wb_en_n, err_n;

    logic [SEL_W-1:0]  mux_sel;
    logic [DATA_W-1:0] cur_data;
    logic              cur_valid;
    logic              sel_legal;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
`endif

    assign req_ready = (state == WB_IDLE);
    assign busy      = (state == WB_WAIT);

    // In WAIT the latched select drives the mux; in IDLE the live request
    assign mux_sel   = (state == WB_WAIT) ? sel_q : req_sel;
    assign sel_legal = ({1'b0, mux_sel} < NUM_SRC_L);
    assign cur_valid = sel_legal && src_valid[mux_sel];

    wb_src_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_data (src_data),
        .sel      (mux_sel),
        .data     (cur_data)
    );

    // Next-state and next-output decode; outputs hold unless a write fires
    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        addr_n    = addr_q;
        wb_en_n   = 1'b0;
        err_n     = 1'b0;
        wb_addr_n = wb_addr;
        wb_data_n = wb_data;
`ifdef WB_TIMEOUT_EN
        cnt_n     = cnt;
`endif
        case (state)
            WB_IDLE: begin
                if (req_valid) begin
                    if (!sel_legal) begin
                        err_n = 1'b1;
                    end else if (cur_valid) begin
                        wb_en_n   = 1'b1;
                        wb_addr_n = req_addr;
                        wb_data_n = cur_data;
                    end else begin
                        state_n = WB_WAIT;
                        sel_n   = req_sel;
                        addr_n  = req_addr;
`ifdef WB_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end
                end
            end
            WB_WAIT: begin
                // Valid data beats a timeout landing in the same cycle
                if (cur_valid) begin
                    wb_en_n   = 1'b1;
                    wb_addr_n = addr_q;
                    wb_data_n = cur_data;
                    state_n   = WB_IDLE;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT)) begin
                    err_n   = 1'b1;
                    state_n = WB_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: state_n = WB_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending WAIT silently
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WB_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            err     <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            sel_q   <= sel_n;
            addr_q  <= addr_n;
            wb_en   <= wb_en_n;
            wb_addr <= wb_addr_n;
            wb_data <= wb_data_n;
            err     <= err_n;
`ifdef WB_TIMEOUT_EN
            cnt     <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: a 4-source instance for the main
// paths and a 3-source instance for the illegal-select case.
module tb_wb_select_pipe;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-source instance
    logic        req_valid, req_ready;
    logic [1:0]  req_sel;
    logic [2:0]  req_addr;
    logic [63:0] src_data;
    logic [3:0]  src_valid;
    logic        wb_en, busy, err;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    // 3-source instance
    logic        req_valid3, req_ready3;
    logic [1:0]  req_sel3;
    logic [2:0]  req_addr3;
    logic [47:0] src_data3;
    logic [2:0]  src_valid3;
    logic        wb_en3, busy3, err3;
    logic [2:0]  wb_addr3;
    logic [15:0] wb_data3;

    wb_select_pipe #(.DATA_W(16), .NUM_SRC(4), .ADDR_W(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_addr(req_addr), .src_data(src_data),
        .src_valid(src_valid), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .busy(busy), .err(err)
    );

    wb_select_pipe #(.DATA_W(16), .NUM_SRC(3), .ADDR_W(3), .TIMEOUT(15)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_sel(req_sel3), .req_addr(req_addr3), .src_data(src_data3),
        .src_valid(src_valid3), .wb_en(wb_en3), .wb_addr(wb_addr3),
        .wb_data(wb_data3), .busy(busy3), .err(err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (wb_en !== 1'b0)     begin errors++; $display("FAIL rst_wb_en got %b exp 0", wb_en); end
        checks++; if (wb_addr !== 3'd0)   begin errors++; $display("FAIL rst_wb_addr got %h exp 0", wb_addr); end
        checks++; if (wb_data !== 16'h0)  begin errors++; $display("FAIL rst_wb_data got %h exp 0", wb_data); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_immediate();
        src_data  = {16'h0, 16'h0, 16'h0, 16'h1234};
        src_valid = 4'b0001;
        req_sel   = 2'(WB_SRC_ALU);
        req_addr  = 3'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (wb_en !== 1'b1)       begin errors++; $display("FAIL imm_en got %b exp 1", wb_en); end
        checks++; if (wb_addr !== 3'd5)     begin errors++; $display("FAIL imm_addr got %h exp 5", wb_addr); end
        checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL imm_data got %h exp 1234", wb_data); end
        checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL imm_ready got %b exp 1", req_ready); end
        tick();
        checks++; if (wb_en !== 1'b0)       begin errors++; $display("FAIL imm_pulse got %b exp 0", wb_en); end
        checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL imm_hold got %h exp 1234", wb_data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sels [3];
        logic [2:0]  addrs[3];
        logic [15:0] exps [3];
        sels  = '{2'd0, 2'd2, 2'd3};
        addrs = '{3'd1, 3'd2, 3'd3};
        exps  = '{16'h1111, 16'h3333, 16'h4444};
        src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        src_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            req_sel = sels[i]; req_addr = addrs[i]; req_valid = 1'b1;
            tick();
            checks++; if (wb_en !== 1'b1)      begin errors++; $display("FAIL b2b_en[%0d] got %b exp 1", i, wb_en); end
            checks++; if (wb_addr !== addrs[i]) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", i, wb_addr, addrs[i]); end
            checks++; if (wb_data !== exps[i])  begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, wb_data, exps[i]); end
        end
        req_valid = 1'b0;
        tick();
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", wb_en); end
    endtask

    task automatic test_load_wait();
        src_data  = 64'h0;
        src_valid = 4'b0000;
        req_sel   = 2'(WB_SRC_RAM);
        req_addr  = 3'd7;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL wait_busy[%0d] got %b exp 1", i, busy); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_ready[%0d] got %b exp 0", i, req_ready); end
            checks++; if (wb_en !== 1'b0)     begin errors++; $display("FAIL wait_en[%0d] got %b exp 0", i, wb_en); end
            if (i == 2) begin
                src_data  = {16'h0, 16'h0, 16'hBEEF, 16'h0};
                src_valid = 4'b0010;
            end
            tick();
        end
        checks++; if (wb_en !== 1'b1)       begin errors++; $display("FAIL load_en got %b exp 1", wb_en); end
        checks++; if (wb_addr !== 3'd7)     begin errors++; $display("FAIL load_addr got %h exp 7", wb_addr); end
        checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL load_data got %h exp beef", wb_data); end
        checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL load_ready got %b exp 1", req_ready); end
        src_data = {16'h0, 16'h0, 16'hDEAD, 16'h0};
        tick();
        checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL load_hold got %h exp beef", wb_data); end
        checks++; if (wb_en !== 1'b0)       begin errors++; $display("FAIL load_pulse got %b exp 0", wb_en); end
        src_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_wait();
        src_valid = 4'b0000;
        req_sel = 2'd1; req_addr = 3'd4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmw_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmw_busy_rst got %b exp 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready got %b exp 1", req_ready); end
        checks++; if (wb_data !== 16'h0)  begin errors++; $display("FAIL rmw_data got %h exp 0", wb_data); end
        src_data  = {16'h0, 16'h0, 16'h5555, 16'h0};
        src_valid = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rmw_no_write[%0d] got %b exp 0", i, wb_en); end
        end
        src_valid = 4'b0000;
    endtask

    task automatic test_illegal_sel();
        src_data3  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        src_valid3 = 3'b111;
        req_sel3 = 2'd3; req_addr3 = 3'd2; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        checks++; if (err3 !== 1'b1)       begin errors++; $display("FAIL ill_err got %b exp 1", err3); end
        checks++; if (wb_en3 !== 1'b0)     begin errors++; $display("FAIL ill_en got %b exp 0", wb_en3); end
        checks++; if (req_ready3 !== 1'b1) begin errors++; $display("FAIL ill_ready got %b exp 1", req_ready3); end
        checks++; if (busy3 !== 1'b0)      begin errors++; $display("FAIL ill_busy got %b exp 0", busy3); end
        tick();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL ill_pulse got %b exp 0", err3); end
        req_sel3 = 2'd2; req_addr3 = 3'd6; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        checks++; if (wb_en3 !== 1'b1 || wb_data3 !== 16'hCCCC || wb_addr3 !== 3'd6)
            begin errors++; $display("FAIL three_src_write got en=%b d=%h a=%h exp en=1 d=cccc a=6", wb_en3, wb_data3, wb_addr3); end
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL three_src_err got %b exp 0", err3); end
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        // Abort case: valid never arrives
        src_valid = 4'b0000;
        req_sel = 2'd1; req_addr = 3'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_pre busy=%b err=%b exp busy=1 err=0", busy, err); end
        tick();
        checks++; if (err !== 1'b1)       begin errors++; $display("FAIL to_err got %b exp 1", err); end
        checks++; if (wb_en !== 1'b0)     begin errors++; $display("FAIL to_en got %b exp 0", wb_en); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL to_ready got %b exp 1", req_ready); end
        tick();
        // Race case: valid arrives in the cycle the count reaches TIMEOUT
        req_sel = 2'd1; req_addr = 3'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        src_data  = {16'h0, 16'h0, 16'hCAFE, 16'h0};
        src_valid = 4'b0010;
        tick();
        checks++; if (wb_en !== 1'b1)       begin errors++; $display("FAIL race_en got %b exp 1", wb_en); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL race_err got %b exp 0", err); end
        checks++; if (wb_data !== 16'hCAFE) begin errors++; $display("FAIL race_data got %h exp cafe", wb_data); end
        checks++; if (wb_addr !== 3'd3)     begin errors++; $display("FAIL race_addr got %h exp 3", wb_addr); end
        src_valid = 4'b0000;
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0; req_sel = '0; req_addr = '0; src_data = '0; src_valid = '0;
        req_valid3 = 1'b0; req_sel3 = '0; req_addr3 = '0; src_data3 = '0; src_valid3 = '0;
        test_reset();
        test_immediate();
        test_back_to_back();
        test_load_wait();
        test_reset_mid_wait();
        test_illegal_sel();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
